game_tick_gen: RTL

GAME_TICK_GEN -- requirements
Module: game_tick_gen

---
 rtl/snake_timing_pkg.sv | 17 +
 rtl/tick_divider.sv | 49 ++++
 rtl/game_tick_gen.sv | 72 +++++++
 3 files changed

// File: rtl/snake_timing_pkg.sv
// Shared timing defaults for the snake game tick generator.
// Holds parameter defaults and the base divider helper.
package snake_timing_pkg;

  localparam int DEF_DIV_W = 20;
  localparam int DEF_FRAME_W = 4;
  localparam int DEF_FRAMES_PER_STEP = 16;
  localparam int DEF_LEVEL_W = 3;
  localparam int DEF_LEVEL_MAX = 7;

  function automatic int base_div_for(input int w);
    return (2 ** w) - 1;
  endfunction

  localparam int DEF_BASE_DIV = base_div_for(DEF_DIV_W);

endpackage

// File: rtl/tick_divider.sv
// Reloadable down-counter producing the frame tick.
// The speed level is latched only at reload.
module tick_divider
  import snake_timing_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int BASE_DIV = DEF_BASE_DIV,
  parameter int LEVEL_W = DEF_LEVEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] level,
  output logic [DIV_W-1:0]   div_cnt,
  output logic               expire,
  output logic               tick
);

  localparam logic [DIV_W-1:0] BASE = DIV_W'(BASE_DIV);

  logic [LEVEL_W-1:0] level_active;
  logic [LEVEL_W-1:0] shamt;
  logic [DIV_W-1:0]   reload;

  // The running period keeps its own level; a new level
  // only takes over at the expiry edge.
  always_comb begin
    expire = enable && (div_cnt == '0);
    shamt = expire ? level : level_active;
    reload = BASE >> shamt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= BASE;
      level_active <= '0;
      tick <= 1'b0;
    end else begin
      tick <= expire;
      if (expire) begin
        div_cnt <= reload;
        level_active <= level;
      end else if (enable) begin
        div_cnt <= div_cnt - DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_tick_gen.sv
// Game timing: frame ticks from a level-scaled divider,
// step ticks on frame-counter wrap.
module game_tick_gen
  import snake_timing_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int BASE_DIV = base_div_for(DIV_W),
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int LEVEL_MAX = DEF_LEVEL_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               level_up,
  input  logic               level_clr,
  output logic [DIV_W-1:0]   div_cnt,
  output logic [FRAME_W-1:0] frame,
  output logic [LEVEL_W-1:0] level,
  output logic               frame_tick,
  output logic               step_tick
);

  localparam logic [FRAME_W-1:0] FRAME_LAST =
    FRAME_W'(FRAMES_PER_STEP - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX =
    LEVEL_W'(LEVEL_MAX);

  logic expire;
  logic frame_last;

  tick_divider #(
    .DIV_W   (DIV_W),
    .BASE_DIV(BASE_DIV),
    .LEVEL_W (LEVEL_W)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .level  (level),
    .div_cnt(div_cnt),
    .expire (expire),
    .tick   (frame_tick)
  );

  assign frame_last = (frame == FRAME_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame <= '0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= expire && frame_last;
      if (expire) begin
        frame <= frame_last ? '0 : frame + FRAME_W'(1);
      end
    end
  end

  // Clear wins over a simultaneous raise.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
    end else if (level_clr) begin
      level <= '0;
    end else if (level_up && level != LVL_MAX) begin
      level <= level + LEVEL_W'(1);
    end
  end

endmodule
